mdec_dma0_feeder: RTL and testbench

- DMA channel-0 style feeder directly upstream of the MDEC register interface.
- Reads 32-bit command/parameter/stream words from system memory in blocks and writes them into MDEC register 0 (regSelect=0).
- Obeys MDEC's Data-In Request and FIFO-not-full signals.
- Moves RLE streams, quant tables and cos tables into MDEC without CPU writes.

---
 rtl/mdec_dma_pkg.sv | 35 +++
 rtl/mdec_dma_wordbuf.sv | 74 +++++++
 rtl/mdec_dma0_feeder.sv | 242 ++++++++++++++++++++++++
 tb/tb_mdec_dma0_feeder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdec_dma_pkg.sv
// -----------------------------------------------------------------------------
// mdec_dma_pkg
// Shared types for the MDEC DMA channel-0 feeder:
//   - state_t     : feeder control states
//   - count_t     : 17-bit word/block counter type, so a 16-bit field of 0
//                   can stand for 65536
//   - COUNT_65536 : the value that replaces a zero size/count field
//   - expand_count: turns a raw 16-bit field into a count_t
// -----------------------------------------------------------------------------
package mdec_dma_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_REQ    = 3'd1,
      XFER        = 3'd2,
      DONE        = 3'd3,
      ABORT_DRAIN = 3'd4
   } state_t;

   typedef logic [16:0] count_t;

   localparam count_t COUNT_65536 = 17'h10000;

   // A 16-bit field of zero means the full 65536.
   function automatic count_t expand_count(input logic [15:0] raw);
      count_t c;
      if (raw == 16'd0) begin
         c = COUNT_65536;
      end else begin
         c = {1'b0, raw};
      end
      return c;
   endfunction

endpackage

// File: rtl/mdec_dma_wordbuf.sv
// -----------------------------------------------------------------------------
// mdec_dma_wordbuf
// Small synchronous word FIFO that holds prefetched memory words until MDEC
// can take them. The head word is available combinationally.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear (wins over push/pop)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : 32-bit word to store
//   pop        : drop the head word (ignored when empty)
//   head       : current head word
//   count      : number of stored words (0..DEPTH)
//   empty      : count == 0
// -----------------------------------------------------------------------------
module mdec_dma_wordbuf #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [31:0]   push_data,
   input  logic          pop,
   output logic [31:0]   head,
   output logic [AW:0]   count,
   output logic          empty
);

   logic [31:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign do_push_s = push && (count_r != (AW+1)'(DEPTH));
   assign do_pop_s  = pop && (count_r != (AW+1)'(0));

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == (AW+1)'(0));

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'd0;
         end
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else if (flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mdec_dma0_feeder.sv
// -----------------------------------------------------------------------------
// mdec_dma0_feeder
// DMA channel-0 style feeder sitting in front of MDEC register 0. Reads words
// from memory in blocks (one read outstanding at a time, prefetching into a
// small buffer) and writes them into MDEC whenever the input FIFO has room.
// Each block starts only after MDEC raises its Data-In Request.
//
// Optional feature macro: MDEC_DMA_ADDR_STEP_EN
//   defined   -> extra input i_addrDec, latched on i_start; 1 = addresses
//                decrement per read instead of incrementing.
//   undefined -> addresses always increment.
//
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start / i_abort   : start pulse (latches config) / cancel pulse
//   i_baseAdr           : first word address
//   i_blockSize         : words per block (0 = 65536)
//   i_blockCount        : number of blocks (0 = 65536)
//   o_busy / o_done     : transfer active / one-cycle completion pulse
//   o_memReq, o_memAdr, i_memAck, i_memValid, i_memData : memory read port
//   i_dmaReq, i_canWrite: MDEC data-in request / input FIFO not full
//   o_regSelect, o_write, o_valueOut : MDEC register write port (reg 0)
// -----------------------------------------------------------------------------
module mdec_dma0_feeder
   import mdec_dma_pkg::*;
#(
   parameter int ADDR_W    = 22,
   parameter int BUF_DEPTH = 4,
   parameter int BUF_AW    = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_baseAdr,
   input  logic [15:0]       i_blockSize,
   input  logic [15:0]       i_blockCount,
`ifdef MDEC_DMA_ADDR_STEP_EN
   input  logic              i_addrDec,
`endif
   output logic              o_busy,
   output logic              o_done,
   output logic              o_memReq,
   output logic [ADDR_W-1:0] o_memAdr,
   input  logic              i_memAck,
   input  logic              i_memValid,
   input  logic [31:0]       i_memData,
   input  logic              i_dmaReq,
   input  logic              i_canWrite,
   output logic              o_regSelect,
   output logic              o_write,
   output logic [31:0]       o_valueOut
);

   state_t            state_r;
   state_t            next_state_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_next_s;
   count_t            block_size_r;
   count_t            blocks_left_r;
   count_t            words_issued_r;
   count_t            words_written_r;
   logic              outstanding_r;
`ifdef MDEC_DMA_ADDR_STEP_EN
   logic              dec_r;
`endif

   logic              start_ok_s;
   logic              req_seen_s;
   logic              mem_req_s;
   logic              write_s;
   logic              push_s;
   logic              flush_s;
   logic              block_done_s;
   logic [31:0]       buf_head_s;
   logic [BUF_AW:0]   buf_count_s;
   logic              buf_empty_s;

   mdec_dma_wordbuf #(
      .DEPTH (BUF_DEPTH),
      .AW    (BUF_AW)
   ) u_wordbuf (
      .clk       (i_clk),
      .rst       (i_rst),
      .flush     (flush_s),
      .push      (push_s),
      .push_data (i_memData),
      .pop       (write_s),
      .head      (buf_head_s),
      .count     (buf_count_s),
      .empty     (buf_empty_s)
   );

`ifdef MDEC_DMA_ADDR_STEP_EN
   assign addr_next_s = dec_r ? (addr_r - ADDR_W'(1)) : (addr_r + ADDR_W'(1));
`else
   assign addr_next_s = addr_r + ADDR_W'(1);
`endif

   // Returned data only enters the buffer while transferring; during an
   // abort (including the abort cycle itself) it is thrown away.
   assign push_s = i_memValid && outstanding_r && (state_r == XFER) && !i_abort;

   // Next-state decode plus the memory-request and MDEC-write strobes.
   always_comb begin
      next_state_s = state_r;
      start_ok_s   = 1'b0;
      req_seen_s   = 1'b0;
      mem_req_s    = 1'b0;
      write_s      = 1'b0;
      flush_s      = 1'b0;
      block_done_s = 1'b0;
      case (state_r)
         IDLE: begin
            // Abort wins over a simultaneous start.
            if (i_start && !i_abort) begin
               start_ok_s   = 1'b1;
               next_state_s = WAIT_REQ;
            end else begin
               next_state_s = IDLE;
            end
         end
         WAIT_REQ: begin
            if (i_abort) begin
               flush_s      = 1'b1;
               next_state_s = ABORT_DRAIN;
            end else if (i_dmaReq) begin
               req_seen_s   = 1'b1;
               next_state_s = XFER;
            end else begin
               next_state_s = WAIT_REQ;
            end
         end
         XFER: begin
            if (i_abort) begin
               flush_s      = 1'b1;
               next_state_s = ABORT_DRAIN;
            end else begin
               // With one read in flight at most, the outstanding read is
               // folded into the !outstanding_r term of the room check.
               mem_req_s = !outstanding_r
                           && (buf_count_s < (BUF_AW+1)'(BUF_DEPTH))
                           && (words_issued_r < block_size_r);
               write_s   = !buf_empty_s && i_canWrite;
               if (write_s && ((words_written_r + 17'd1) == block_size_r)) begin
                  block_done_s = 1'b1;
                  if (blocks_left_r == 17'd1) begin
                     next_state_s = DONE;
                  end else begin
                     next_state_s = WAIT_REQ;
                  end
               end else begin
                  next_state_s = XFER;
               end
            end
         end
         DONE: begin
            if (i_abort) begin
               flush_s      = 1'b1;
               next_state_s = ABORT_DRAIN;
            end else begin
               next_state_s = IDLE;
            end
         end
         ABORT_DRAIN: begin
            flush_s = 1'b1;
            // Leave once the in-flight read (if any) has come back.
            if (!outstanding_r || i_memValid) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = ABORT_DRAIN;
            end
         end
         default: begin
            flush_s      = 1'b1;
            next_state_s = IDLE;
         end
      endcase
   end

   // State, address and transfer counters.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r         <= IDLE;
         addr_r          <= {ADDR_W{1'b0}};
         block_size_r    <= 17'd0;
         blocks_left_r   <= 17'd0;
         words_issued_r  <= 17'd0;
         words_written_r <= 17'd0;
         outstanding_r   <= 1'b0;
`ifdef MDEC_DMA_ADDR_STEP_EN
         dec_r           <= 1'b0;
`endif
      end else begin
         state_r <= next_state_s;
         if (start_ok_s) begin
            addr_r          <= i_baseAdr;
            block_size_r    <= expand_count(i_blockSize);
            blocks_left_r   <= expand_count(i_blockCount);
            words_issued_r  <= 17'd0;
            words_written_r <= 17'd0;
`ifdef MDEC_DMA_ADDR_STEP_EN
            dec_r           <= i_addrDec;
`endif
         end
         if (req_seen_s) begin
            words_issued_r  <= 17'd0;
            words_written_r <= 17'd0;
         end
         if (mem_req_s && i_memAck) begin
            outstanding_r  <= 1'b1;
            addr_r         <= addr_next_s;
            words_issued_r <= words_issued_r + 17'd1;
         end else if (i_memValid) begin
            outstanding_r <= 1'b0;
         end
         if (write_s) begin
            words_written_r <= words_written_r + 17'd1;
         end
         if (block_done_s) begin
            blocks_left_r <= blocks_left_r - 17'd1;
         end
      end
   end

   // MDEC write data is the buffer head in the cycle it is popped.
   always_comb begin
      if (write_s) begin
         o_valueOut = buf_head_s;
      end else begin
         o_valueOut = 32'd0;
      end
   end

   assign o_busy      = (state_r != IDLE);
   assign o_done      = (state_r == DONE) && !i_abort;
   assign o_memReq    = mem_req_s;
   assign o_memAdr    = addr_r;
   assign o_write     = write_s;
   assign o_regSelect = 1'b0;

endmodule

// File: tb/tb_mdec_dma0_feeder.sv
module tb_mdec_dma0_feeder;

   localparam int ADDR_W    = 22;
   localparam int BUF_DEPTH = 4;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_start;
   logic              i_abort;
   logic [ADDR_W-1:0] i_baseAdr;
   logic [15:0]       i_blockSize;
   logic [15:0]       i_blockCount;
   logic              i_addrDec;
   logic              o_busy;
   logic              o_done;
   logic              o_memReq;
   logic [ADDR_W-1:0] o_memAdr;
   logic              i_memAck;
   logic              i_memValid;
   logic [31:0]       i_memData;
   logic              i_dmaReq;
   logic              i_canWrite;
   logic              o_regSelect;
   logic              o_write;
   logic [31:0]       o_valueOut;

   mdec_dma0_feeder #(.ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH), .BUF_AW(2)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
      .i_baseAdr(i_baseAdr), .i_blockSize(i_blockSize), .i_blockCount(i_blockCount),
`ifdef MDEC_DMA_ADDR_STEP_EN
      .i_addrDec(i_addrDec),
`endif
      .o_busy(o_busy), .o_done(o_done), .o_memReq(o_memReq), .o_memAdr(o_memAdr),
      .i_memAck(i_memAck), .i_memValid(i_memValid), .i_memData(i_memData),
      .i_dmaReq(i_dmaReq), .i_canWrite(i_canWrite), .o_regSelect(o_regSelect),
      .o_write(o_write), .o_valueOut(o_valueOut)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;

   // Memory/MDEC observation state
   logic [31:0]       wr_log[$];
   logic [ADDR_W-1:0] adr_log[$];
   logic [ADDR_W-1:0] pend_adr;
   int wr_cnt = 0, ack_cnt = 0, done_cnt = 0, cw_viol = 0, occ_viol = 0;
   int pend_cnt = 0, lat_cfg = 1;
   bit ack_rand = 1'b0;

   function automatic logic [31:0] memval(input logic [ADDR_W-1:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory responder: one read at a time, ack (optionally delayed), data lat_cfg cycles later.
   initial begin
      i_memAck = 1'b0; i_memValid = 1'b0; i_memData = 32'd0;
      forever begin
         @(negedge i_clk);
         i_memValid = 1'b0;
         i_memAck   = 1'b0;
         i_memData  = $urandom();
         if (i_rst === 1'b1) begin
            pend_cnt = 0;
         end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               i_memValid = 1'b1;
               i_memData  = memval(pend_adr);
            end
         end else if (o_memReq === 1'b1 && (!ack_rand || $urandom_range(0, 2) != 0)) begin
            i_memAck = 1'b1;
            pend_adr = o_memAdr;
            adr_log.push_back(o_memAdr);
            ack_cnt++;
            pend_cnt = lat_cfg;
         end
      end
   end

   // MDEC-side monitor
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_write === 1'b1) begin
            wr_log.push_back(o_valueOut);
            wr_cnt++;
            if (i_canWrite !== 1'b1) cw_viol++;
         end
         if (o_done === 1'b1) done_cnt++;
         if (ack_cnt - wr_cnt > BUF_DEPTH) occ_viol++;
      end
   end

   task automatic clr();
      wr_log.delete(); adr_log.delete();
      wr_cnt = 0; ack_cnt = 0; cw_viol = 0; occ_viol = 0;
   endtask

   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [15:0] sz,
                             input logic [15:0] cnt);
      i_baseAdr = base; i_blockSize = sz; i_blockCount = cnt; i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget, input bit rand_cw);
      int n = 0;
      while (o_busy !== 1'b0 && n < budget) begin
         if (rand_cw) i_canWrite = ($urandom_range(0, 9) < 7);
         tick();
         n++;
      end
      i_canWrite = 1'b1;
      chk(tag, 64'(n < budget), 64'd1);
   endtask

   task automatic wait_wr(input string tag, input int target, input int budget);
      int n = 0;
      while (wr_cnt < target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 64'(n < budget), 64'd1);
   endtask

   // Reference: word i of the transfer comes from base +/- i (mod 2^ADDR_W).
   task automatic check_xfer(input string tag, input logic [ADDR_W-1:0] base,
                             input int nwords, input bit down, input bit chk_adr);
      logic [ADDR_W-1:0] ea;
      chk({tag, "_nwr"}, 64'(wr_log.size()), 64'(nwords));
      if (chk_adr) chk({tag, "_nadr"}, 64'(adr_log.size()), 64'(nwords));
      for (int i = 0; i < nwords; i++) begin
         ea = down ? (base - ADDR_W'(i)) : (base + ADDR_W'(i));
         if (chk_adr && i < adr_log.size()) chk({tag, "_adr"}, 64'(adr_log[i]), 64'(ea));
         if (i < wr_log.size()) chk({tag, "_data"}, 64'(wr_log[i]), 64'(memval(ea)));
      end
      chk({tag, "_cwviol"}, 64'(cw_viol), 64'd0);
      chk({tag, "_occviol"}, 64'(occ_viol), 64'd0);
   endtask

   initial begin
      int d0, a0, n, sz, cnt;
      logic [ADDR_W-1:0] base;
      i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_baseAdr = '0;
      i_blockSize = 16'd0; i_blockCount = 16'd0; i_addrDec = 1'b0;
      i_dmaReq = 1'b1; i_canWrite = 1'b1;
      #1;
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_memreq", 64'(o_memReq), 64'd0);
      chk("rst_write", 64'(o_write), 64'd0);
      chk("rst_memadr", 64'(o_memAdr), 64'd0);
      chk("rst_value", 64'(o_valueOut), 64'd0);
      chk("rst_regsel", 64'(o_regSelect), 64'd0);
      repeat (3) @(posedge i_clk);
      #1; i_rst = 1'b0;
      tick();

      // start and abort together while idle: abort wins
      i_start = 1'b1; i_abort = 1'b1; i_baseAdr = 22'h100; i_blockSize = 16'd4; i_blockCount = 16'd1;
      tick();
      i_start = 1'b0; i_abort = 1'b0;
      tick();
      chk("idle_abort_busy", 64'(o_busy), 64'd0);

      // basic
      clr(); lat_cfg = 1; ack_rand = 1'b0; d0 = done_cnt;
      start_xfer(22'h100, 16'd4, 16'd1);
      chk("basic_busy", 64'(o_busy), 64'd1);
      wait_idle("basic_to", 100, 1'b0);
      check_xfer("basic", 22'h100, 4, 1'b0, 1'b1);
      chk("basic_done", 64'(done_cnt - d0), 64'd1);

      // multi-block with request gaps
      clr(); i_dmaReq = 1'b0; d0 = done_cnt;
      start_xfer(22'h100, 16'd2, 16'd3);
      for (int b = 0; b < 3; b++) begin
         i_dmaReq = 1'b1; tick(); i_dmaReq = 1'b0;
         wait_wr("mb_blk_to", 2 * (b + 1), 60);
         repeat (10) tick();
         chk("mb_blk_writes", 64'(wr_cnt), 64'(2 * (b + 1)));
      end
      wait_idle("mb_to", 20, 1'b0);
      i_dmaReq = 1'b1;
      check_xfer("mb", 22'h100, 6, 1'b0, 1'b1);
      chk("mb_done", 64'(done_cnt - d0), 64'd1);

      // backpressure: canWrite low for cycles 5..20 after start
      clr(); d0 = done_cnt;
      start_xfer(22'h180, 16'd8, 16'd1);
      for (int c = 1; c <= 30; c++) begin
         i_canWrite = !(c >= 5 && c <= 20);
         if (c == 20) begin
            chk("bp_held", 64'(ack_cnt - wr_cnt), 64'(BUF_DEPTH));
            chk("bp_no_outstanding", 64'(pend_cnt), 64'd0);
         end
         tick();
      end
      wait_idle("bp_to", 100, 1'b0);
      check_xfer("bp", 22'h180, 8, 1'b0, 1'b1);
      chk("bp_done", 64'(done_cnt - d0), 64'd1);

      // abort on the 6th write with a read outstanding
      clr(); lat_cfg = 3; d0 = done_cnt;
      start_xfer(22'h300, 16'd16, 16'd1);
      wait_wr("ab_5wr_to", 5, 200);
      i_canWrite = 1'b0;
      n = 0;
      while (!((ack_cnt - wr_cnt - (pend_cnt > 0 ? 1 : 0)) >= 1 && pend_cnt > 0) && n < 100) begin
         tick(); n++;
      end
      chk("ab_setup_to", 64'(n < 100), 64'd1);
      a0 = ack_cnt;
      i_canWrite = 1'b1; i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("ab_write_stopped", 64'(wr_cnt), 64'd5);
      wait_idle("ab_idle_to", 20, 1'b0);
      repeat (6) tick();
      chk("ab_no_late_write", 64'(wr_cnt), 64'd5);
      chk("ab_no_new_read", 64'(ack_cnt), 64'(a0));
      chk("ab_no_done", 64'(done_cnt - d0), 64'd0);
      check_xfer("ab", 22'h300, 5, 1'b0, 1'b0);

      // clean transfer after abort: no stale words may leak out
      clr(); lat_cfg = 1; d0 = done_cnt;
      start_xfer(22'h400, 16'd3, 16'd1);
      wait_idle("post_ab_to", 60, 1'b0);
      check_xfer("post_ab", 22'h400, 3, 1'b0, 1'b1);
      chk("post_ab_done", 64'(done_cnt - d0), 64'd1);

      // address wrap, plus a start pulse during busy that must be ignored
      clr(); d0 = done_cnt;
      start_xfer(22'h3FFFFE, 16'd4, 16'd1);
      tick(); tick();
      start_xfer(22'h200, 16'd1, 16'd1);
      wait_idle("wrap_to", 60, 1'b0);
      repeat (4) tick();
      chk("wrap_stay_idle", 64'(o_busy), 64'd0);
      check_xfer("wrap", 22'h3FFFFE, 4, 1'b0, 1'b1);
      chk("wrap_done", 64'(done_cnt - d0), 64'd1);

      // randomized transfers against the reference
      for (int t = 0; t < 4; t++) begin
         clr(); d0 = done_cnt;
         base = ADDR_W'($urandom());
         sz = $urandom_range(1, 10); cnt = $urandom_range(1, 3);
         lat_cfg = $urandom_range(1, 3); ack_rand = 1'b1;
         start_xfer(base, 16'(sz), 16'(cnt));
         wait_idle("rnd_to", 1500, 1'b1);
         check_xfer("rnd", base, sz * cnt, 1'b0, 1'b1);
         chk("rnd_done", 64'(done_cnt - d0), 64'd1);
      end
      ack_rand = 1'b0; lat_cfg = 1;

`ifdef MDEC_DMA_ADDR_STEP_EN
      clr(); d0 = done_cnt; i_addrDec = 1'b1;
      start_xfer(22'h10, 16'd3, 16'd1);
      i_addrDec = 1'b0;
      wait_idle("dec_to", 60, 1'b0);
      check_xfer("dec", 22'h10, 3, 1'b1, 1'b1);
      chk("dec_done", 64'(done_cnt - d0), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
